// File: rtl/mapache64_ctrl_pkg.sv
// Shared types and constants for the gamepad polling path.
// Poll FSM state encoding and button bit positions.
package mapache64_ctrl_pkg;

  localparam int BUTTON_W = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_EN   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_CAPTURE   = 3'd5
  } poll_state_e;

endpackage

// File: rtl/controller_edge_tracker.sv
// Per-pad button snapshot plus sticky pressed-since-ack bits.
// A capture in the same cycle as an ack keeps only the fresh edges.
module controller_edge_tracker
  import mapache64_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                capture,
  input  logic                ack,
  input  logic [BUTTON_W-1:0] data,
  output logic [BUTTON_W-1:0] buttons,
  output logic [BUTTON_W-1:0] pressed
);

  logic [BUTTON_W-1:0] kept;

  assign kept = ack ? '0 : pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons <= '0;
      pressed <= '0;
    end else if (capture) begin
      buttons <= data;
      pressed <= kept | (data & ~buttons);
    end else if (ack) begin
      pressed <= '0;
    end
  end

endmodule

// File: rtl/controller_poll_scheduler.sv
// Drives controller_interface fetches per frame or on CPU demand and
// captures the resulting button bytes into a stable snapshot.
module controller_poll_scheduler
  import mapache64_ctrl_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2,
  parameter int TIMEOUT_CYCLES  = 32,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                vblank_i,
  input  logic                                auto_en_i,
  input  logic                                poll_req_i,
  input  logic                                clk_en_i,
  input  logic [BUTTON_W*NUM_CONTROLLERS-1:0] data_LIST_i,
  input  logic [NUM_CONTROLLERS-1:0]          ack_LIST_i,
  output logic                                start_fetch_o,
  output logic                                busy_o,
  output logic [BUTTON_W*NUM_CONTROLLERS-1:0] buttons_LIST_o,
  output logic [BUTTON_W*NUM_CONTROLLERS-1:0] pressed_LIST_o,
  output logic                                new_data_o,
  output logic                                timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] S_LOAD = TW'(SETTLE_CYCLES);

  poll_state_e   state_q;
  poll_state_e   state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          pending_q;
  logic          trigger;
  logic          abort;
  logic          capture;
  logic          t_zero;
  logic [TW-1:0] t_dec;

  assign trigger = (auto_en_i & vblank_i) | poll_req_i;
  assign capture = (state_q == ST_CAPTURE);
  assign t_zero  = (timer_q == '0);
  assign t_dec   = t_zero ? '0 : timer_q - TW'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    abort   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger || pending_q) state_d = ST_START;
      end
      ST_START: begin
        timer_d = T_LOAD;
        state_d = ST_WAIT_EN;
      end
      ST_WAIT_EN: begin
        if (clk_en_i) begin
          state_d = ST_WAIT_DONE;
          timer_d = T_LOAD;
        end else if (t_zero) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else begin
          timer_d = t_dec;
        end
      end
      ST_WAIT_DONE: begin
        if (!clk_en_i) begin
          state_d = ST_SETTLE;
          timer_d = S_LOAD;
        end else if (t_zero) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else begin
          timer_d = t_dec;
        end
      end
      ST_SETTLE: begin
        if (t_zero) state_d = ST_CAPTURE;
        else        timer_d = t_dec;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      start_fetch_o <= 1'b0;
      busy_o        <= 1'b0;
      new_data_o    <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      start_fetch_o <= (state_d == ST_START);
      busy_o        <= (state_d != ST_IDLE);
      new_data_o    <= capture;
      if (state_q == ST_IDLE) pending_q <= 1'b0;
      else if (trigger)       pending_q <= 1'b1;
      if (capture)    timeout_o <= 1'b0;
      else if (abort) timeout_o <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_pad
    controller_edge_tracker u_trk (
      .clk     (clk),
      .rst_n   (rst_n),
      .capture (capture),
      .ack     (ack_LIST_i[g]),
      .data    (data_LIST_i[g*BUTTON_W +: BUTTON_W]),
      .buttons (buttons_LIST_o[g*BUTTON_W +: BUTTON_W]),
      .pressed (pressed_LIST_o[g*BUTTON_W +: BUTTON_W])
    );
  end

endmodule

// File: tb/tb_controller_poll_scheduler.sv
// Directed bench for controller_poll_scheduler with a scripted
// stand-in for the controller_interface shifter.
module tb_controller_poll_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblank_i;
  logic        auto_en_i;
  logic        poll_req_i;
  logic        clk_en_i;
  logic [15:0] data_LIST_i;
  logic [1:0]  ack_LIST_i;
  logic        start_fetch_o;
  logic        busy_o;
  logic [15:0] buttons_LIST_o;
  logic [15:0] pressed_LIST_o;
  logic        new_data_o;
  logic        timeout_o;

  int n_cmp = 0;
  int n_err = 0;
  int sf_cnt = 0;
  int nd_cnt = 0;
  int sf_base;
  int nd_base;

  controller_poll_scheduler #(
    .NUM_CONTROLLERS (2),
    .TIMEOUT_CYCLES  (32),
    .SETTLE_CYCLES   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vblank_i       (vblank_i),
    .auto_en_i      (auto_en_i),
    .poll_req_i     (poll_req_i),
    .clk_en_i       (clk_en_i),
    .data_LIST_i    (data_LIST_i),
    .ack_LIST_i     (ack_LIST_i),
    .start_fetch_o  (start_fetch_o),
    .busy_o         (busy_o),
    .buttons_LIST_o (buttons_LIST_o),
    .pressed_LIST_o (pressed_LIST_o),
    .new_data_o     (new_data_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_fetch_o) sf_cnt++;
    if (new_data_o)    nd_cnt++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start_fetch_o && n < 20) begin
      tick();
      n++;
    end
    chk("start_seen", start_fetch_o, 1);
  endtask

  task automatic wait_new();
    int n = 0;
    while (!new_data_o && n < 40) begin
      tick();
      n++;
    end
    chk("new_data_seen", new_data_o, 1);
  endtask

  task automatic run_shift(input logic [15:0] d);
    wait_start();
    tick(2);
    clk_en_i = 1'b1;
    tick(8);
    data_LIST_i = d;
    clk_en_i = 1'b0;
    wait_new();
  endtask

  initial begin
    rst_n = 1'b0;
    vblank_i = 1'b0;
    auto_en_i = 1'b0;
    poll_req_i = 1'b0;
    clk_en_i = 1'b0;
    data_LIST_i = '0;
    ack_LIST_i = '0;
    tick(3);
    chk("rst_start", start_fetch_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_buttons", buttons_LIST_o, 0);
    chk("rst_pressed", pressed_LIST_o, 0);
    chk("rst_new", new_data_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst_n = 1'b1;
    tick(2);

    // auto poll on vblank
    auto_en_i = 1'b1;
    vblank_i = 1'b1;
    tick();
    vblank_i = 1'b0;
    run_shift(16'h1081);
    chk("auto_buttons", buttons_LIST_o, 16'h1081);
    chk("auto_pressed", pressed_LIST_o, 16'h1081);
    tick(10);
    chk("auto_one_start", sf_cnt, 1);
    chk("auto_one_new", nd_cnt, 1);

    // vblank ignored when auto disabled
    auto_en_i = 1'b0;
    vblank_i = 1'b1;
    tick();
    vblank_i = 1'b0;
    tick(5);
    chk("noauto_busy", busy_o, 0);
    chk("noauto_starts", sf_cnt, 1);

    // edge accumulation then ack
    poll_req_i = 1'b1;
    tick();
    poll_req_i = 1'b0;
    run_shift(16'h1083);
    chk("edge_pressed", pressed_LIST_o, 16'h1083);
    tick();
    ack_LIST_i = 2'b01;
    tick();
    ack_LIST_i = 2'b00;
    chk("ack_pressed", pressed_LIST_o, 16'h1000);
    chk("ack_buttons", buttons_LIST_o, 16'h1083);

    // ack colliding with capture: fresh edges survive
    ack_LIST_i = 2'b01;
    poll_req_i = 1'b1;
    tick();
    poll_req_i = 1'b0;
    run_shift(16'h1087);
    ack_LIST_i = 2'b00;
    chk("coll_pressed", pressed_LIST_o, 16'h1004);
    chk("coll_buttons", buttons_LIST_o, 16'h1087);
    tick(5);

    // pending request during a fetch, second one dropped
    sf_base = sf_cnt;
    poll_req_i = 1'b1;
    tick();
    poll_req_i = 1'b0;
    wait_start();
    tick(2);
    clk_en_i = 1'b1;
    tick();
    poll_req_i = 1'b1;
    tick();
    poll_req_i = 1'b0;
    tick();
    poll_req_i = 1'b1;
    tick();
    poll_req_i = 1'b0;
    tick(4);
    clk_en_i = 1'b0;
    wait_new();
    tick();
    chk("pend_restart", start_fetch_o, 1);
    run_shift(16'h1087);
    tick(50);
    chk("pend_starts", sf_cnt - sf_base, 2);
    chk("pend_idle", busy_o, 0);
    chk("pend_pressed", pressed_LIST_o, 16'h1004);

    // timeout with no shifter activity
    nd_base = nd_cnt;
    poll_req_i = 1'b1;
    tick();
    poll_req_i = 1'b0;
    wait_start();
    tick(20);
    chk("to_not_early", timeout_o, 0);
    chk("to_busy_mid", busy_o, 1);
    for (int i = 0; i < 40; i++) if (!timeout_o) tick();
    chk("to_flag", timeout_o, 1);
    chk("to_idle", busy_o, 0);
    chk("to_buttons", buttons_LIST_o, 16'h1087);
    chk("to_no_new", nd_cnt - nd_base, 0);
    poll_req_i = 1'b1;
    tick();
    poll_req_i = 1'b0;
    run_shift(16'h2187);
    chk("to_cleared", timeout_o, 0);
    chk("to_good_buttons", buttons_LIST_o, 16'h2187);
    chk("to_good_pressed", pressed_LIST_o, 16'h3104);
    tick(5);

    // reset while settling
    sf_base = sf_cnt;
    nd_base = nd_cnt;
    poll_req_i = 1'b1;
    tick();
    poll_req_i = 1'b0;
    wait_start();
    tick(2);
    clk_en_i = 1'b1;
    tick(8);
    data_LIST_i = 16'h5555;
    clk_en_i = 1'b0;
    tick(2);
    chk("mid_busy_pre", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_buttons", buttons_LIST_o, 0);
    chk("mid_pressed", pressed_LIST_o, 0);
    chk("mid_start", start_fetch_o, 0);
    chk("mid_new", new_data_o, 0);
    chk("mid_timeout", timeout_o, 0);
    tick();
    rst_n = 1'b1;
    tick(20);
    chk("post_no_new", nd_cnt - nd_base, 0);
    chk("post_no_start", sf_cnt - sf_base, 1);
    chk("post_buttons", buttons_LIST_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
